// File: rtl/fwd_hazard_unit_pkg.sv
// Shared rv32i types for the forwarding/hazard slice: register and word aliases,
// the hold-entry record and the regfile select code.
package fwd_hazard_unit_pkg;

    typedef logic [4:0]  rv32i_reg;
    typedef logic [31:0] rv32i_word;

    localparam int fwd_sel_regfile = 0;

    typedef struct packed {
        logic      valid;
        rv32i_reg  rd;
        rv32i_word data;
    } hold_entry_t;

    // Architectural register match; x0 never matches anything.
    function automatic logic reg_match(input rv32i_reg a, input rv32i_reg b);
        return (a == b) && (a != '0);
    endfunction

endpackage

// File: rtl/fwd_hold_buf.sv
// History of committed writebacks: a shift register (entry 0 youngest) with a
// parallel read-out of every entry for the bypass search.
module fwd_hold_buf
    import fwd_hazard_unit_pkg::*;
#(
    parameter int HOLD_DEPTH = 2,
    parameter int XLEN       = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [4:0]                 push_rd,
    input  logic [XLEN-1:0]            push_data,
    output logic [HOLD_DEPTH-1:0]      hold_valid,
    output logic [HOLD_DEPTH*5-1:0]    hold_rd,
    output logic [HOLD_DEPTH*XLEN-1:0] hold_data
);

    logic [HOLD_DEPTH-1:0] valid_reg;
    rv32i_reg              rd_reg   [HOLD_DEPTH];
    logic [XLEN-1:0]       data_reg [HOLD_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < HOLD_DEPTH; gi++) begin : g_entry
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg[gi] <= 1'b0;
                        rd_reg[gi]    <= '0;
                        data_reg[gi]  <= '0;
                    end else if (push) begin
                        valid_reg[gi] <= 1'b1;
                        rd_reg[gi]    <= push_rd;
                        data_reg[gi]  <= push_data;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        valid_reg[gi] <= 1'b0;
                        rd_reg[gi]    <= '0;
                        data_reg[gi]  <= '0;
                    end else if (push) begin
                        valid_reg[gi] <= valid_reg[gi-1];
                        rd_reg[gi]    <= rd_reg[gi-1];
                        data_reg[gi]  <= data_reg[gi-1];
                    end
                end
            end

            assign hold_valid[gi]              = valid_reg[gi];
            assign hold_rd[gi*5 +: 5]          = rd_reg[gi];
            assign hold_data[gi*XLEN +: XLEN]  = data_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass and load-use hazard detection for the EX stage, with a
// saturating count of stalled cycles.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int NUM_SRC        = 2,
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_LAT       = 1,
    parameter int HOLD_DEPTH     = 2,
    parameter int XLEN           = 32,
    localparam int SELW          = $clog2(NUM_FWD_STAGES + HOLD_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*5-1:0]           ex_src_addr,
    input  logic [NUM_SRC-1:0]             ex_src_valid,
    input  logic [NUM_FWD_STAGES*5-1:0]    stg_rd,
    input  logic [NUM_FWD_STAGES-1:0]      stg_we,
    input  logic [NUM_FWD_STAGES-1:0]      stg_load,
    input  logic [NUM_FWD_STAGES*XLEN-1:0] stg_data,
    input  logic                           wb_commit,
    input  logic [4:0]                     wb_rd,
    input  logic [XLEN-1:0]                wb_data,
    input  logic                           cnt_clr,
    output logic [NUM_SRC-1:0]             src_fwd_flag,
    output logic [NUM_SRC*SELW-1:0]        src_fwd_sel,
    output logic [NUM_SRC*XLEN-1:0]        src_fwd_data,
    output logic                           stall_req,
    output logic [31:0]                    stall_cycles
);

    logic [HOLD_DEPTH-1:0]      hold_valid;
    logic [HOLD_DEPTH*5-1:0]    hold_rd;
    logic [HOLD_DEPTH*XLEN-1:0] hold_data;
    logic [NUM_SRC-1:0]         src_not_ready;
    logic [31:0]                stall_cycles_reg;

    fwd_hold_buf #(
        .HOLD_DEPTH (HOLD_DEPTH),
        .XLEN       (XLEN)
    ) u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .push       (wb_commit && (wb_rd != 5'd0)),
        .push_rd    (wb_rd),
        .push_data  (wb_data),
        .hold_valid (hold_valid),
        .hold_rd    (hold_rd),
        .hold_data  (hold_data)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            rv32i_reg        addr;
            logic            hit;
            logic            not_ready;
            logic [SELW-1:0] win_sel;
            logic [XLEN-1:0] win_data;

            assign addr = ex_src_addr[gi*5 +: 5];

            // Youngest match wins; once hit is set, older producers are ignored
            // even if they would stall.
            always_comb begin
                hit       = 1'b0;
                not_ready = 1'b0;
                win_sel   = '0;
                win_data  = '0;
                if (ex_src_valid[gi] && (addr != '0)) begin
                    for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                        if (!hit && stg_we[k] && reg_match(stg_rd[k*5 +: 5], addr)) begin
                            hit       = 1'b1;
                            win_sel   = SELW'(k + 1);
                            win_data  = stg_data[k*XLEN +: XLEN];
                            not_ready = stg_load[k] && (k < LOAD_LAT);
                        end
                    end
                    for (int h = 0; h < HOLD_DEPTH; h++) begin
                        if (!hit && hold_valid[h] && (hold_rd[h*5 +: 5] == addr)) begin
                            hit      = 1'b1;
                            win_sel  = SELW'(1 + NUM_FWD_STAGES + h);
                            win_data = hold_data[h*XLEN +: XLEN];
                        end
                    end
                end
            end

            assign src_not_ready[gi]              = not_ready;
            assign src_fwd_flag[gi]               = hit && !not_ready;
            assign src_fwd_sel[gi*SELW +: SELW]   = src_fwd_flag[gi] ? win_sel
                                                                     : SELW'(fwd_sel_regfile);
            assign src_fwd_data[gi*XLEN +: XLEN]  = src_fwd_flag[gi] ? win_data : '0;
        end
    endgenerate

    assign stall_req = |src_not_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles_reg <= '0;
        end else if (cnt_clr) begin
            stall_cycles_reg <= '0;
        end else if (stall_req && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: a queue-based reference model predicts each
// cycle's lookup result and a negedge monitor compares the DUT against it.
module tb_fwd_hazard_unit;

    localparam int NS = 2;
    localparam int NF = 2;
    localparam int LL = 1;
    localparam int HD = 2;
    localparam int XL = 32;
    localparam int SW = $clog2(NF + HD + 1);

    typedef struct packed {
        logic [NS-1:0]    flag;
        logic [NS*SW-1:0] sel;
        logic [NS*XL-1:0] data;
        logic             stall;
        logic [31:0]      cnt;
    } exp_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NS*5-1:0]  ex_src_addr = '0;
    logic [NS-1:0]    ex_src_valid = '0;
    logic [NF*5-1:0]  stg_rd = '0;
    logic [NF-1:0]    stg_we = '0;
    logic [NF-1:0]    stg_load = '0;
    logic [NF*XL-1:0] stg_data = '0;
    logic             wb_commit = 1'b0;
    logic [4:0]       wb_rd = '0;
    logic [XL-1:0]    wb_data = '0;
    logic             cnt_clr = 1'b0;
    logic [NS-1:0]    src_fwd_flag;
    logic [NS*SW-1:0] src_fwd_sel;
    logic [NS*XL-1:0] src_fwd_data;
    logic             stall_req;
    logic [31:0]      stall_cycles;

    exp_t        sb[$];
    wb_t         hist[$];
    logic [31:0] exp_cnt = '0;
    int          checks = 0;
    int          errors = 0;

    fwd_hazard_unit #(
        .NUM_SRC(NS), .NUM_FWD_STAGES(NF), .LOAD_LAT(LL), .HOLD_DEPTH(HD), .XLEN(XL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ex_src_addr  (ex_src_addr),
        .ex_src_valid (ex_src_valid),
        .stg_rd       (stg_rd),
        .stg_we       (stg_we),
        .stg_load     (stg_load),
        .stg_data     (stg_data),
        .wb_commit    (wb_commit),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .cnt_clr      (cnt_clr),
        .src_fwd_flag (src_fwd_flag),
        .src_fwd_sel  (src_fwd_sel),
        .src_fwd_data (src_fwd_data),
        .stall_req    (stall_req),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        ex_src_addr = '0; ex_src_valid = '0;
        stg_rd = '0; stg_we = '0; stg_load = '0; stg_data = '0;
        wb_commit = 1'b0; wb_rd = '0; wb_data = '0; cnt_clr = 1'b0;
    endtask

    task automatic set_stage(input int k, input logic we, input logic ld,
                             input logic [4:0] rd, input logic [31:0] d);
        stg_we[k] = we; stg_load[k] = ld; stg_rd[k*5 +: 5] = rd; stg_data[k*XL +: XL] = d;
    endtask

    task automatic set_src(input int s, input logic v, input logic [4:0] a);
        ex_src_valid[s] = v; ex_src_addr[s*5 +: 5] = a;
    endtask

    // Predict the current cycle from the current inputs, then advance the model one edge.
    task automatic step();
        exp_t        e;
        logic        any_nr;
        logic [4:0]  a;
        logic        found;
        logic        nr;
        int          sel;
        logic [31:0] d;
        e = '0;
        any_nr = 1'b0;
        for (int s = 0; s < NS; s++) begin
            a = ex_src_addr[s*5 +: 5];
            found = 1'b0; nr = 1'b0; sel = 0; d = '0;
            if (ex_src_valid[s] && a != 5'd0) begin
                for (int k = 0; k < NF; k++) begin
                    if (!found && stg_we[k] && stg_rd[k*5 +: 5] == a) begin
                        found = 1'b1;
                        if (stg_load[k] && k < LL) nr = 1'b1;
                        else begin sel = k + 1; d = stg_data[k*XL +: XL]; end
                    end
                end
                for (int h = 0; h < hist.size(); h++) begin
                    if (!found && hist[h].rd == a) begin
                        found = 1'b1; sel = 1 + NF + h; d = hist[h].data;
                    end
                end
            end
            if (found && !nr) begin
                e.flag[s] = 1'b1;
                e.sel[s*SW +: SW] = SW'(sel);
                e.data[s*XL +: XL] = d;
            end
            any_nr = any_nr | nr;
        end
        e.stall = any_nr;
        e.cnt = exp_cnt;
        sb.push_back(e);
        @(posedge clk);
        if (cnt_clr) exp_cnt = '0;
        else if (any_nr && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
        if (wb_commit && wb_rd != 5'd0) begin
            hist.push_front('{rd: wb_rd, data: wb_data});
            if (hist.size() > HD) void'(hist.pop_back());
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("flag",  64'(src_fwd_flag), 64'(e.flag));
                check("sel",   64'(src_fwd_sel),  64'(e.sel));
                check("data",  64'(src_fwd_data), 64'(e.data));
                check("stall", 64'(stall_req),    64'(e.stall));
                check("cnt",   64'(stall_cycles), 64'(e.cnt));
                $display("txn t=%0t flag=%b sel=%h data=%h stall=%b cnt=%0d",
                         $time, src_fwd_flag, src_fwd_sel, src_fwd_data, stall_req, stall_cycles);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        check("reset_cnt", 64'(stall_cycles), 64'd0);
        check("reset_flag", 64'(src_fwd_flag), 64'd0);

        // 1: commits and a stall, then a mid-run reset wipes hold and counter
        wb_commit = 1'b1; wb_rd = 5'd3; wb_data = 32'h33; step();
        wb_rd = 5'd4; wb_data = 32'h44; step();
        idle(); set_stage(0, 1'b1, 1'b1, 5'd7, 32'h0); set_src(1, 1'b1, 5'd7); step();
        idle();
        rst = 1'b0;
        hist.delete();
        exp_cnt = '0;
        #2 check("midreset_cnt", 64'(stall_cycles), 64'd0);
        #4 rst = 1'b1;
        @(posedge clk); #1;
        set_src(0, 1'b1, 5'd3);
        #1 check("after_reset_flag", 64'(src_fwd_flag[0]), 64'd0);
        check("after_reset_sel", 64'(src_fwd_sel[SW-1:0]), 64'd0);
        step();

        // 2: youngest stage wins
        idle(); cnt_clr = 1'b1; step();
        idle(); set_stage(0, 1'b1, 1'b0, 5'd5, 32'hA); set_stage(1, 1'b1, 1'b0, 5'd5, 32'hB);
        set_src(0, 1'b1, 5'd5);
        #1 check("prio_data", 64'(src_fwd_data[XL-1:0]), 64'hA);
        step();

        // 3: load-use stall, then forward from stage 1
        idle(); set_stage(0, 1'b1, 1'b1, 5'd7, 32'h0); set_src(1, 1'b1, 5'd7);
        #1 check("loaduse_stall", 64'(stall_req), 64'd1);
        step();
        idle(); set_stage(1, 1'b1, 1'b1, 5'd7, 32'h77); set_src(1, 1'b1, 5'd7);
        #1 check("loaduse_fwd", 64'(src_fwd_data[XL +: XL]), 64'h77);
        check("loaduse_cnt", 64'(stall_cycles), 64'd1);
        step();

        // 4: younger ALU result shadows an older load
        idle(); set_stage(0, 1'b1, 1'b0, 5'd7, 32'h1); set_stage(1, 1'b1, 1'b1, 5'd7, 32'h9);
        set_src(0, 1'b1, 5'd7); step();

        // 5: x0 never forwards or stalls
        idle(); set_stage(0, 1'b1, 1'b1, 5'd0, 32'hDEAD); set_src(0, 1'b1, 5'd0);
        #1 check("x0_stall", 64'(stall_req), 64'd0);
        step();

        // 6: hold eviction
        idle(); wb_commit = 1'b1; wb_rd = 5'd3; wb_data = 32'h33; step();
        wb_rd = 5'd4; wb_data = 32'h44; step();
        idle(); set_src(0, 1'b1, 5'd3);
        #1 check("hold_sel", 64'(src_fwd_sel[SW-1:0]), 64'd4);
        step();
        idle(); wb_commit = 1'b1; wb_rd = 5'd9; wb_data = 32'h99; step();
        idle(); set_src(0, 1'b1, 5'd3);
        #1 check("evict_flag", 64'(src_fwd_flag[0]), 64'd0);
        step();

        // Randomized traffic on a small register window to force frequent matches
        for (int n = 0; n < 500; n++) begin
            for (int s = 0; s < NS; s++)
                set_src(s, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)));
            for (int k = 0; k < NF; k++)
                set_stage(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 7)), $urandom);
            wb_commit = 1'($urandom_range(0, 1));
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            cnt_clr = 1'($urandom_range(0, 29) == 0);
            step();
        end

        idle();
        @(negedge clk); #1;
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
